// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// Round-robin between ports A and B, with an optional bounded lock that lets
// the last winner keep the RAM for up to MAX_BURST consecutive grants.
// Out-of-range addresses are consumed without touching memory and flagged
// with a one-cycle error pulse.
module ram_arbiter #(
    parameter int DATA_W    = 19,
    parameter int ADDR_W    = 7,
    parameter int DEPTH     = 64,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              lock_a,
    input  logic              lock_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              err_a,
    output logic              err_b,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [BW-1:0]   MAX_L   = BW'(MAX_BURST);

    // last_gnt: 0 = port A won most recently, 1 = port B
    logic              last_gnt_q, last_gnt_d;
    // previous cycle's winner asked to keep the grant
    logic              lock_vld_q, lock_vld_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              rvalid_a_q, rvalid_a_d;
    logic              rvalid_b_q, rvalid_b_d;
    logic              err_a_q, err_a_d;
    logic              err_b_q, err_b_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

    logic in_range_a, in_range_b;
    logic lock_force;
    logic mem_hit;

    assign in_range_a = ({1'b0, addr_a} < DEPTH_L);
    assign in_range_b = ({1'b0, addr_b} < DEPTH_L);

    // Arbitration: bounded lock first, then round-robin, then single requester
    always_comb begin
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        lock_force = lock_vld_q && (burst_q < MAX_L) && (last_gnt_q ? req_b : req_a);
        if (rst_n) begin
            if (lock_force) begin
                gnt_a = ~last_gnt_q;
                gnt_b = last_gnt_q;
            end else if (req_a && req_b) begin
                gnt_a = last_gnt_q;
                gnt_b = ~last_gnt_q;
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    // Memory-side mux: drive the winner's command only for in-range accesses
    always_comb begin
        mem_hit   = (gnt_a && in_range_a) || (gnt_b && in_range_b);
        mem_en    = mem_hit;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_hit) begin
            mem_we    = gnt_b ? we_b    : we_a;
            mem_addr  = gnt_b ? addr_b  : addr_a;
            mem_wdata = gnt_b ? wdata_b : wdata_a;
        end
    end

    // Response outputs: pulses are masked while reset is held, read data
    // passes straight through from the RAM on the valid cycle and holds after
    always_comb begin
        rvalid_a = rvalid_a_q & rst_n;
        rvalid_b = rvalid_b_q & rst_n;
        err_a    = err_a_q & rst_n;
        err_b    = err_b_q & rst_n;
        rdata_a  = rvalid_a ? mem_rdata : rdata_a_q;
        rdata_b  = rvalid_b ? mem_rdata : rdata_b_q;
    end

    // Next-state: grant history, burst counting and response scheduling
    always_comb begin
        last_gnt_d = last_gnt_q;
        lock_vld_d = 1'b0;
        burst_d    = burst_q;
        if (gnt_a || gnt_b) begin
            last_gnt_d = gnt_b;
            lock_vld_d = gnt_b ? lock_b : lock_a;
            // a repeat grant following a locked one extends the burst
            if (lock_vld_q && (gnt_b == last_gnt_q)) begin
                burst_d = (burst_q < MAX_L) ? burst_q + BW'(1) : burst_q;
            end else begin
                burst_d = BW'(1);
            end
        end
        rvalid_a_d = gnt_a && !we_a && in_range_a;
        rvalid_b_d = gnt_b && !we_b && in_range_b;
        err_a_d    = gnt_a && !in_range_a;
        err_b_d    = gnt_b && !in_range_b;
        rdata_a_d  = rdata_a;
        rdata_b_d  = rdata_b;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
            lock_vld_q <= 1'b0;
            burst_q    <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            err_a_q    <= 1'b0;
            err_b_q    <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            lock_vld_q <= lock_vld_d;
            burst_q    <= burst_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            err_a_q    <= err_a_d;
            err_b_q    <= err_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

endmodule
